// File: rtl/mvu_pkg.sv
// Shared definitions for the MVU interconnect: default geometry, stall-counter width
// and the source-index type.
package mvu_pkg;

  localparam int unsigned NMVU_DEF    = 8;
  localparam int unsigned W_DEF       = 64;
  localparam int unsigned BMVUA_DEF   = $clog2(NMVU_DEF);
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [BMVUA_DEF-1:0] mvu_idx_t;

endpackage

// File: rtl/mvu_xbar_if.sv
// Send/receive handshake bundle between the MVU cores (master) and mvu_xbar (slave).
interface mvu_xbar_if
  import mvu_pkg::*;
#(
  parameter int unsigned NMVU = NMVU_DEF,
  parameter int unsigned W    = W_DEF
);

  logic [NMVU-1:0]   send_en;
  logic [NMVU-1:0]   send_rdy;
  logic [NMVU*W-1:0] send_word;
  logic [NMVU-1:0]   recv_vld;
  logic [NMVU-1:0]   recv_en;
  logic [NMVU*W-1:0] recv_word;

  modport master (
    output send_en, send_word, recv_en,
    input  send_rdy, recv_vld, recv_word
  );

  modport slave (
    input  send_en, send_word, recv_en,
    output send_rdy, recv_vld, recv_word
  );

endinterface

// File: rtl/mvu_xbar_fifo.sv
// Single receiver FIFO with synchronous flush and show-ahead head; a full FIFO
// refuses a push even when it is popped on the same edge.
module mvu_xbar_fifo #(
  parameter  int unsigned W     = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push/pop against the current occupancy
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    push_ok_s = push & ~full_s;
    pop_ok_s  = pop & (count_r != '0);
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is never read while empty, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= din;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;

endmodule

// File: rtl/mvu_xbar.sv
// Buffered multicast interconnect between MVU cores: each receiver selects one source
// and owns a FIFO. Optional per-source stall counters under MVU_XBAR_STATS_EN.
module mvu_xbar
  import mvu_pkg::*;
#(
  parameter  int unsigned NMVU  = NMVU_DEF,
  parameter  int unsigned W     = W_DEF,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned BMVUA = $clog2(NMVU)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_clr,
  input  logic [NMVU*BMVUA-1:0]   ic_recv_from,
  input  logic [NMVU-1:0]         ic_recv_act,
`ifdef MVU_XBAR_STATS_EN
  output logic [NMVU*STALL_CNT_W-1:0] send_stall_cnt,
`endif
  mvu_xbar_if.slave               bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  typedef logic [BMVUA-1:0] src_idx_t;

  src_idx_t          sel_r [NMVU];
  logic [NMVU-1:0]   act_r;
  logic [NMVU-1:0]   full_s;
  logic [NMVU-1:0]   push_s;
  logic [NMVU-1:0]   pop_s;
  logic [NMVU-1:0]   send_rdy_s;
  logic [NMVU-1:0]   recv_vld_s;
  logic [NMVU*W-1:0] recv_word_s;
  logic [W-1:0]      din_s  [NMVU];
  logic [W-1:0]      head_s [NMVU];
  logic [CW-1:0]     count_s [NMVU];

  // Receiver routing configuration, loaded only during ic_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NMVU; r++) sel_r[r] <= src_idx_t'(r);
      act_r <= '0;
    end else if (ic_clr) begin
      for (int r = 0; r < NMVU; r++) sel_r[r] <= ic_recv_from[r*BMVUA +: BMVUA];
      act_r <= ic_recv_act;
    end
  end

  // Source ready: AND of not-full over all active receivers listening to it
  always_comb begin
    logic rdy_v;
    send_rdy_s = '0;
    for (int s = 0; s < NMVU; s++) begin
      rdy_v = ~ic_clr;
      for (int r = 0; r < NMVU; r++) begin
        rdy_v = rdy_v & ~(act_r[r] & (sel_r[r] == src_idx_t'(s)) & full_s[r]);
      end
      send_rdy_s[s] = rdy_v;
    end
  end

  // Source muxing into each receiver and multicast push
  always_comb begin
    int idx;
    push_s = '0;
    for (int r = 0; r < NMVU; r++) begin
      idx       = int'(sel_r[r]);
      din_s[r]  = bus.send_word[idx*W +: W];
      push_s[r] = act_r[r] & bus.send_en[idx] & send_rdy_s[idx];
    end
  end

  // Receiver side: valid, pop qualification and zeroed head when invalid
  always_comb begin
    recv_vld_s  = '0;
    pop_s       = '0;
    recv_word_s = '0;
    for (int r = 0; r < NMVU; r++) begin
      recv_vld_s[r]          = (count_s[r] != '0) & ~ic_clr;
      pop_s[r]               = bus.recv_en[r] & recv_vld_s[r];
      recv_word_s[r*W +: W]  = recv_vld_s[r] ? head_s[r] : '0;
    end
  end

  for (genvar g = 0; g < NMVU; g++) begin : g_rx
    mvu_xbar_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (ic_clr),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (din_s[g]),
      .head  (head_s[g]),
      .count (count_s[g]),
      .full  (full_s[g])
    );
  end

  assign bus.send_rdy  = send_rdy_s;
  assign bus.recv_vld  = recv_vld_s;
  assign bus.recv_word = recv_word_s;

`ifdef MVU_XBAR_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r [NMVU];

  // Saturating per-source stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NMVU; s++) stall_cnt_r[s] <= '0;
    end else if (ic_clr) begin
      for (int s = 0; s < NMVU; s++) stall_cnt_r[s] <= '0;
    end else begin
      for (int s = 0; s < NMVU; s++) begin
        if (bus.send_en[s] && !send_rdy_s[s] && (stall_cnt_r[s] != {STALL_CNT_W{1'b1}}))
          stall_cnt_r[s] <= stall_cnt_r[s] + STALL_CNT_W'(1);
      end
    end
  end

  // Flatten counters onto the port
  always_comb begin
    send_stall_cnt = '0;
    for (int s = 0; s < NMVU; s++) send_stall_cnt[s*STALL_CNT_W +: STALL_CNT_W] = stall_cnt_r[s];
  end
`endif

endmodule

// File: tb/tb_mvu_xbar.sv
// Directed self-checking bench for mvu_xbar (NMVU=8, W=64, DEPTH=4).
module tb_mvu_xbar;
  import mvu_pkg::*;

  localparam int unsigned NM = 8;
  localparam int unsigned WW = 64;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            ic_clr = 1'b0;
  logic [NM*3-1:0] ic_recv_from = '0;
  logic [NM-1:0]   ic_recv_act  = '0;
`ifdef MVU_XBAR_STATS_EN
  logic [NM*16-1:0] send_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mvu_xbar_if #(.NMVU(NM), .W(WW)) bus ();

  mvu_xbar #(.NMVU(NM), .W(WW), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_clr       (ic_clr),
    .ic_recv_from (ic_recv_from),
    .ic_recv_act  (ic_recv_act),
`ifdef MVU_XBAR_STATS_EN
    .send_stall_cnt (send_stall_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rword(input int r);
    return bus.recv_word[r*WW +: WW];
  endfunction

  function automatic logic [NM*3-1:0] ident();
    logic [NM*3-1:0] v;
    for (int i = 0; i < NM; i++) v[i*3 +: 3] = mvu_idx_t'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [NM*3-1:0] from, input logic [NM-1:0] act);
    ic_recv_from = from;
    ic_recv_act  = act;
    ic_clr       = 1'b1;
    #1;
    check("clr_vld", 64'(bus.recv_vld), 64'h0);
    check("clr_rdy", 64'(bus.send_rdy), 64'h0);
    tick();
    ic_clr = 1'b0;
    #1;
  endtask

  initial begin
    logic [NM*3-1:0] f;
    bus.send_en   = '0;
    bus.send_word = '0;
    bus.recv_en   = '0;
    #3;
    check("rst_vld", 64'(bus.recv_vld), 64'h0);
    check("rst_rdy", 64'(bus.send_rdy), 64'hFF);
    check("rst_word3", rword(3), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Point-to-point: source 3 to receiver 3
    cfg(ident(), 8'hFF);
    bus.send_word[3*WW +: WW] = 64'hA5;
    bus.send_en[3] = 1'b1;
    #1;
    check("p2p_rdy3", 64'(bus.send_rdy[3]), 64'h1);
    tick();
    bus.send_en = '0;
    #1;
    check("p2p_vld", 64'(bus.recv_vld), 64'h08);
    check("p2p_word", rword(3), 64'hA5);
    bus.recv_en[3] = 1'b1;
    tick();
    bus.recv_en = '0;
    #1;
    check("p2p_popped", 64'(bus.recv_vld), 64'h0);
    check("p2p_word0", rword(3), 64'h0);

    // Multicast: receivers 1,2,5 from source 0; only 5 pops
    f = ident();
    f[1*3 +: 3] = 3'd0;
    f[2*3 +: 3] = 3'd0;
    f[5*3 +: 3] = 3'd0;
    cfg(f, 8'h26);
    for (int k = 0; k < 4; k++) begin
      bus.send_word[0 +: WW] = 64'h100 + 64'(k);
      bus.send_en[0] = 1'b1;
      bus.recv_en[5] = 1'b1;
      #1;
      check("mc_rdy0", 64'(bus.send_rdy[0]), 64'h1);
      tick();
      check("mc_r5", rword(5), 64'h100 + 64'(k));
    end
    check("mc_full_rdy0", 64'(bus.send_rdy[0]), 64'h0);
    check("mc_vld", 64'(bus.recv_vld), 64'h26);
    check("mc_r1_head", rword(1), 64'h100);

    // Full plus pop on the same edge: push still blocked
    bus.send_word[0 +: WW] = 64'hBAD;
    bus.recv_en = 8'h26;
    #1;
    check("fp_rdy0_pre", 64'(bus.send_rdy[0]), 64'h0);
    tick();
    bus.send_en = '0;
    bus.recv_en = '0;
    #1;
    check("fp_rdy0_post", 64'(bus.send_rdy[0]), 64'h1);
    check("fp_vld", 64'(bus.recv_vld), 64'h06);
    bus.recv_en = 8'h06;
    for (int k = 1; k < 4; k++) begin
      check("drain_r1", rword(1), 64'h100 + 64'(k));
      check("drain_r2", rword(2), 64'h100 + 64'(k));
      tick();
    end
    bus.recv_en = '0;
    #1;
    check("drain_empty", 64'(bus.recv_vld), 64'h0);

    // Inactive sink: source 6 has no active listener
    for (int k = 0; k < 3; k++) begin
      bus.send_word[6*WW +: WW] = 64'h600 + 64'(k);
      bus.send_en[6] = 1'b1;
      #1;
      check("sink_rdy6", 64'(bus.send_rdy[6]), 64'h1);
      tick();
    end
    bus.send_en = '0;
    #1;
    check("sink_vld", 64'(bus.recv_vld), 64'h0);

    // Mid-stream flush with reconfiguration
    bus.send_en[0] = 1'b1;
    bus.send_word[0 +: WW] = 64'h200;
    tick();
    bus.send_word[0 +: WW] = 64'h201;
    tick();
    bus.send_en = '0;
    #1;
    check("fl_vld_pre", 64'(bus.recv_vld), 64'h26);
    f = ident();
    f[4*3 +: 3] = 3'd6;
    cfg(f, 8'h10);
    check("fl_vld_post", 64'(bus.recv_vld), 64'h0);
    check("fl_rdy", 64'(bus.send_rdy), 64'hFF);
    bus.send_word[6*WW +: WW] = 64'h77;
    bus.send_en[6] = 1'b1;
    tick();
    check("fl_newsel_vld", 64'(bus.recv_vld), 64'h10);
    check("fl_newsel_word", rword(4), 64'h77);

    // Asynchronous reset mid-transfer
    bus.send_word[6*WW +: WW] = 64'h78;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", 64'(bus.recv_vld), 64'h0);
    check("ar_word4", rword(4), 64'h0);
    check("ar_rdy", 64'(bus.send_rdy), 64'hFF);
    bus.send_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.send_word[4*WW +: WW] = 64'h44;
    bus.send_en[4] = 1'b1;
    tick();
    bus.send_en = '0;
    #1;
    check("ar_act_cleared", 64'(bus.recv_vld), 64'h0);

`ifdef MVU_XBAR_STATS_EN
    // Stall counter: fill receiver 0, then hold source 0 blocked
    cfg(ident(), 8'hFF);
    bus.send_en[0] = 1'b1;
    repeat (4) tick();
    check("st_rdy0", 64'(bus.send_rdy[0]), 64'h0);
    check("st_cnt0_zero", 64'(send_stall_cnt[15:0]), 64'h0);
    repeat (3) tick();
    check("st_cnt0_3", 64'(send_stall_cnt[15:0]), 64'h3);
    repeat (70000) @(posedge clk);
    #1;
    check("st_cnt0_sat", 64'(send_stall_cnt[15:0]), 64'hFFFF);
    cfg(ident(), 8'hFF);
    bus.send_en = '0;
    check("st_cnt0_clr", 64'(send_stall_cnt[15:0]), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mvu_xbar.md
# mvu_xbar

Buffered, multicast-capable data interconnect between the MVU cores in the top level, and the successor to the unbuffered `interconn`. Every receiver port selects one source MVU and owns a FIFO of depth `DEPTH`. A source word is delivered to all receivers that select it, and the source is back-pressured when any of those receivers is full. It sits between each MVU's interconnect read port (`rdi_*`) and its interconnect write port (`wri_*`).

## Interface
- `NMVU`, 8: number of MVU ports, ≥2.
- `W`, 64: word width, equal to MVU `N`.
- `DEPTH`, 4: per-receiver FIFO depth; power of 2, ≥2.
- `BMVUA`, `$clog2(NMVU)`: source-index width (derived localparam).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ic_clr`, input, 1: synchronous flush plus config load.
- `ic_recv_from`, input, NMVU*BMVUA: per-receiver source select; sampled only while `ic_clr`=1.
- `ic_recv_act`, input, NMVU: per-receiver active bit; sampled only while `ic_clr`=1.
- `send_en`, input, NMVU: source word offered.
- `send_rdy`, output, NMVU: source may transfer.
- `send_word`, input, NMVU*W: source words.
- `recv_vld`, output, NMVU: receiver FIFO non-empty.
- `recv_en`, input, NMVU: receiver pop.
- `recv_word`, output, NMVU*W: receiver FIFO head.
- `send_stall_cnt`, output, NMVU*16: present only with `MVU_XBAR_STATS_EN`.

## Operation
- Per-receiver state:
  - `sel[r]` (BMVUA bits)
  - `act[r]`
  - FIFO storage of `DEPTH` words, read pointer, write pointer, and count of `$clog2(DEPTH+1)` bits.
- `full[r]` = (count == DEPTH); `recv_vld[r]` = (count != 0) and not `ic_clr`.
- `send_rdy[s]` = not `ic_clr`, AND over all r with `act[r]` and `sel[r]`==s of not `full[r]`.
  - No active receiver selects s: `send_rdy[s]`=1 and accepted words are discarded (sink).
- Transfer from s occurs when `send_en[s]` and `send_rdy[s]`. The word is pushed into every active receiver r with `sel[r]`==s (multicast) on the same edge.
- Pop occurs when `recv_en[r]` and `recv_vld[r]`: read pointer advances. `recv_en` while not valid is ignored.
- `recv_word[r]` is show-ahead: it is the head entry while valid and is forced to 0 when `recv_vld[r]`=0.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- A full FIFO blocks push even if popped in the same cycle. `send_rdy` never depends on `recv_en`, so there is no combinational path from receiver to sender.
- Pointers wrap modulo DEPTH.
- `ic_clr`=1 on an edge:
  - all FIFOs are emptied;
  - `sel` and `act` are loaded from the ports;
  - any concurrent `send_en` or `recv_en` is ignored.
- Multiple receivers may select the same source. A receiver may select its own MVU index (loopback).

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - FIFOs empty, `sel[r]`=r, `act`=0;
  - `recv_vld`=0, `recv_word`=0, `send_rdy`=1 (all sinks), `send_stall_cnt`=0.
- Reset is honoured mid-transfer; all buffered data is lost.
- Push-to-`recv_vld` latency is 1 cycle. `recv_word` is valid in the same cycle that `recv_vld` rises.
- Sustained throughput is 1 word/cycle/receiver when the consumer pops every cycle and DEPTH ≥2.
- `send_rdy` and `recv_vld` are combinational from registered state and `ic_clr` only.

## Configuration
- Macro: `MVU_XBAR_STATS_EN`.
- Defined:
  - Per source, a 16-bit saturating counter increments on every cycle with `send_en[s]`=1 and `send_rdy[s]`=0.
  - The counter is cleared by reset and by `ic_clr`, and holds at 16'hFFFF once it saturates.
  - The `send_stall_cnt` port exists.
- Undefined: no counters and no `send_stall_cnt` port; behaviour is otherwise identical.

## Structure
- Shared package `mvu_pkg` holds:
  - the default `NMVU`/`W`;
  - the stall-counter width constant (16);
  - a typedef for the source index.
- One sub-module, `mvu_xbar_fifo`: single FIFO with push/pop/flush, count, full and show-ahead head. It is instantiated NMVU times in a generate loop.
- Source muxing and ready-AND reduction live in `mvu_xbar`.

## Test plan
- Reset, then `ic_clr` with sel = {r: r}, act = all 1. Send 0xA5 from MVU 3 -> `recv_vld[3]`=1 next cycle with word 0xA5; all other receivers stay invalid.
- Multicast: receivers 1, 2 and 5 select source 0; push 4 words while only receiver 5 pops (DEPTH=4).
  - The 4th push fills receivers 1 and 2, and `send_rdy[0]` drops to 0 after it.
  - Receivers 1/2 return 4 words in order.
- Full plus pop in the same cycle on receiver 1: push is blocked and count goes from 4 to 3. Next cycle `send_rdy[0]`=1.
- Inactive sink: no active receiver selects source 6 -> `send_rdy[6]`=1 constantly, and no receiver ever sees its data.
- Mid-stream flush and reset:
  - `ic_clr` asserted with 2 words buffered -> `recv_vld`=0 the next cycle, and the new `sel` takes effect.
  - `rst_n` low mid-transfer -> all outputs take their reset values immediately.
- With `MVU_XBAR_STATS_EN`: hold source 0 blocked for 70000 cycles -> `send_stall_cnt[0]` = 16'hFFFF; `ic_clr` -> 0.
